optical_frame_serializer: RTL and testbench

- Sits directly downstream of `transmitter`, which computes parity over a 28-bit word.
- Accepts a 28-bit word plus that parity bit over a valid/ready handshake.
- Emits one serial on-off-keyed optical frame on `tx_out`: preamble, data MSB-first, parity, then stop/guard bits.
- Each bit is held for a programmable number of clock cycles, so the LED/laser driver sees a fixed symbol rate.

---
 rtl/optical_pkg.sv | 34 +++
 rtl/bit_timer.sv | 38 +++
 rtl/optical_frame_serializer.sv | 129 ++++++++++++
 tb/tb_optical_frame_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/optical_pkg.sv
// Shared constants and state type for the optical link (transmitter, serializer, receiver).
// Frame layout: preamble, payload MSB-first, parity, low guard bits.
package optical_pkg;

  localparam int unsigned DATA_W     = 28;
  localparam int unsigned PREAMBLE_W = 8;
  localparam logic [PREAMBLE_W-1:0] PREAMBLE = 8'b1010_1011;
  localparam int unsigned STOP_BITS  = 2;

  // Preamble, payload and parity travel through one shift register.
  localparam int unsigned FRAME_W = PREAMBLE_W + DATA_W + 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // The bit index must cover the longest field, whichever it is.
  localparam int unsigned IDX_MAX = max3(DATA_W, PREAMBLE_W, STOP_BITS);
  localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StParity,
    StStop
  } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Symbol-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulsing bit_tick on the
// last cycle of each bit. Holds at 0 whenever enable is low.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/optical_frame_serializer.sv
// On-off-keyed frame serializer: accepts a word plus parity, then drives preamble, payload
// MSB-first, parity and low guard bits on tx_out, each held for CLKS_PER_BIT cycles.
module optical_frame_serializer
  import optical_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy_out,
  output logic              frame_done
);

  tx_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_tick;
  logic             timer_en;
  logic             accept;

  assign timer_en = (state_q != StIdle);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (timer_en),
    .bit_tick(bit_tick)
  );

  assign ready_out = rst && (state_q == StIdle);
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = {PREAMBLE, data_in, parity_in};
          idx_d   = '0;
          state_d = StPreamble;
        end
      end
      StPreamble: begin
        if (bit_tick) begin
          shift_d = shift_q << 1;
          if (idx_q == IDX_W'(PREAMBLE_W - 1)) begin
            idx_d   = '0;
            state_d = StData;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = shift_q << 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = StParity;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          shift_d = shift_q << 1;
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    // Output bit is chosen from the next state so tx_out changes on the same edge as the FSM.
    tx_d = 1'b0;
    if ((state_d == StPreamble) || (state_d == StData) || (state_d == StParity)) begin
      tx_d = shift_d[FRAME_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy_out   = (state_q != StIdle);
  assign frame_done = done_q;

endmodule

// File: tb/tb_optical_frame_serializer.sv
// Self-checking bench for optical_frame_serializer with CLKS_PER_BIT=4; expected serial
// streams come from a bit-list model of the frame format.
module tb_optical_frame_serializer;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [27:0] data_in = '0;
  logic        parity_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        tx_out;
  logic        busy_out;
  logic        frame_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          exp_q[$];

  optical_frame_serializer #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .parity_in (parity_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .busy_out  (busy_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame as a list of symbols: preamble, word MSB-first, parity, two low guard bits.
  function automatic void build(input logic [27:0] w, input logic p);
    logic [7:0] pre;
    pre = 8'b1010_1011;
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(pre[i]);
    for (int i = 27; i >= 0; i--) exp_q.push_back(w[i]);
    exp_q.push_back(p);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accept edge; ends in the frame_done cycle.
  task automatic frame_body(input logic [27:0] w, input logic p, input bit hold,
                            input bit disturb);
    int n;
    build(w, p);
    n = exp_q.size() * CPB;
    check("frame_len", n, 156);
    for (int j = 0; j < n; j++) begin
      if (j > 0) step();
      check("tx_bit", tx_out, exp_q[j / CPB]);
      check("busy_high", busy_out, 1);
      check("done_low", frame_done, 0);
      check("ready_low", ready_out, 0);
      if (disturb) begin
        data_in   = $urandom;
        parity_in = $urandom_range(1, 0);
        if (!hold) valid_in = $urandom_range(1, 0);
      end else if (!hold) begin
        valid_in = 1'b0;
      end
    end
    if (!hold) valid_in = 1'b0;
    step();
    check("done_pulse", frame_done, 1);
    check("ready_at_done", ready_out, 1);
    check("tx_idle", tx_out, 0);
    check("busy_idle", busy_out, 0);
  endtask

  task automatic send(input logic [27:0] w, input logic p, input bit hold, input bit disturb);
    check("ready_before_accept", ready_out, 1);
    data_in   = w;
    parity_in = p;
    valid_in  = 1'b1;
    step();
    frame_body(w, p, hold, disturb);
    if (!hold) begin
      step();
      check("done_one_cycle", frame_done, 0);
    end
  endtask

  initial begin
    logic [27:0] w;
    logic        p;

    // Reset with valid held high.
    rst      = 1'b0;
    valid_in = 1'b1;
    data_in  = $urandom;
    repeat (2) begin
      step();
      check("rst_tx", tx_out, 0);
      check("rst_ready", ready_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_done", frame_done, 0);
    end
    rst      = 1'b1;
    valid_in = 1'b0;
    step();
    check("post_rst_ready", ready_out, 1);
    check("post_rst_busy", busy_out, 0);

    send(28'h0000001, 1'b1, 1'b0, 1'b0);
    send(28'hFFFFFFE, 1'b0, 1'b0, 1'b0);

    // Back-to-back with valid held: second word accepted in the frame_done cycle.
    send(28'h94BA8F8, 1'b0, 1'b1, 1'b0);
    data_in   = 28'h0000001;
    parity_in = 1'b1;
    step();
    frame_body(28'h0000001, 1'b1, 1'b0, 1'b0);
    step();

    // Inputs scrambled every cycle while busy.
    w = $urandom;
    p = $urandom_range(1, 0);
    send(w, p, 1'b0, 1'b1);

    // Reset during data bit 10.
    w = $urandom;
    p = $urandom_range(1, 0);
    data_in   = w;
    parity_in = p;
    valid_in  = 1'b1;
    step();
    valid_in = 1'b0;
    build(w, p);
    for (int j = 0; j <= 72; j++) begin
      if (j > 0) step();
      check("pre_abort_tx", tx_out, exp_q[j / CPB]);
    end
    rst = 1'b0;
    step();
    check("abort_tx", tx_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_ready", ready_out, 0);
    check("abort_done", frame_done, 0);
    rst = 1'b1;
    step();
    check("abort_release_ready", ready_out, 1);
    check("abort_release_done", frame_done, 0);
    repeat (4) begin
      step();
      check("abort_no_done", frame_done, 0);
      check("abort_idle_tx", tx_out, 0);
    end

    // Random frames after recovery.
    repeat (3) begin
      w = $urandom;
      p = $urandom_range(1, 0);
      send(w, p, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
